// File: rtl/axi_cmd_arbiter.sv
// Two-requester round-robin command arbiter feeding a single AXI master's start interface.
// Optional BUSY watchdog compiled in with `define ARB_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module axi_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        m_aclk,
    input  logic        m_aresetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [45:0] req0_cmd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [45:0] req1_cmd,
    output logic        write_en,
    output logic        read_en,
    output logic [31:0] ax_addr,
    output logic [7:0]  ax_len,
    output logic [2:0]  ax_size,
    output logic [1:0]  ax_burst,
    input  logic        xfer_done,
    output logic        grant_id,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("axi_cmd_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    state_t      state_q, state_d;
    logic        rr_last_q;   // requester granted most recently (valid once rr_seen_q is set)
    logic        rr_seen_q;   // cleared by reset so requester 0 wins the first tie
    logic        rw_q;
    logic        pick1;
    logic        accept;
    logic        release_busy;
    logic        expire;
    logic [45:0] sel_cmd;

    // Tie goes to whoever was not granted last; a lone requester always wins.
    assign pick1        = (req0_valid && req1_valid) ? (rr_seen_q && !rr_last_q) : req1_valid;
    assign accept       = (state_q == IDLE) && (req0_valid || req1_valid);
    assign sel_cmd      = pick1 ? req1_cmd : req0_cmd;
    assign release_busy = (state_q == BUSY) && (xfer_done || expire);

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q;

    assign expire      = (state_q == BUSY) && !xfer_done && (wd_cnt_q == TIMEOUT_LAST);
    assign timeout_err = expire;

    always_ff @(posedge m_aclk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            wd_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wd_cnt_q <= '0;
        end else if (state_q == BUSY) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge m_aclk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b0;
            rr_seen_q <= 1'b0;
            rw_q      <= 1'b0;
            grant_id  <= 1'b0;
            ax_addr   <= '0;
            ax_len    <= '0;
            ax_size   <= '0;
            ax_burst  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_id <= pick1;
                rw_q     <= sel_cmd[45];
                ax_addr  <= sel_cmd[44:13];
                ax_len   <= sel_cmd[12:5];
                ax_size  <= sel_cmd[4:2];
                ax_burst <= sel_cmd[1:0];
            end
            if (release_busy) begin
                rr_last_q <= grant_id;
                rr_seen_q <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block is given a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req0_ready = !pick1;
                    req1_ready = pick1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                write_en = rw_q;
                read_en  = !rw_q;
                state_d  = BUSY;
            end
            BUSY: begin
                if (release_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed self-checking bench for axi_cmd_arbiter; timeout scenario selected by ARB_TIMEOUT_EN.
module tb_axi_cmd_arbiter;

    logic        m_aclk = 1'b0;
    logic        m_aresetn = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [45:0] req0_cmd = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [45:0] req1_cmd = '0;
    logic        write_en;
    logic        read_en;
    logic [31:0] ax_addr;
    logic [7:0]  ax_len;
    logic [2:0]  ax_size;
    logic [1:0]  ax_burst;
    logic        xfer_done = 1'b0;
    logic        grant_id;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    axi_cmd_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .m_aclk      (m_aclk),
        .m_aresetn   (m_aresetn),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_cmd    (req0_cmd),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_cmd    (req1_cmd),
        .write_en    (write_en),
        .read_en     (read_en),
        .ax_addr     (ax_addr),
        .ax_len      (ax_len),
        .ax_size     (ax_size),
        .ax_burst    (ax_burst),
        .xfer_done   (xfer_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 m_aclk = ~m_aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [45:0] mk_cmd(input logic rw, input logic [31:0] addr,
                                           input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
        return {rw, addr, len, size, burst};
    endfunction

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge m_aclk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {req0_ready, req1_ready, write_en, read_en, grant_id, busy, timeout_err}, 7'd0);
        check({tag, "_ax"}, {ax_addr, ax_len, ax_size, ax_burst}, 45'd0);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        xfer_done  = 1'b0;
        m_aresetn  = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick();
        tick();
        m_aresetn = 1'b1;
        tick();
    endtask

    initial begin
        // ---------- reset ----------
        #1;
        do_reset();

        // ---------- single write from req0 ----------
        req0_cmd   = mk_cmd(1'b1, 32'h100, 8'd3, 3'd2, 2'd1);
        req0_valid = 1'b1;
        req1_cmd   = mk_cmd(1'b0, 32'hDEAD, 8'd9, 3'd1, 2'd0);
        #1;
        check("w_ready0", req0_ready, 1'b1);
        check("w_ready1", req1_ready, 1'b0);
        check("w_idle_en", {write_en, read_en}, 2'b00);
        tick();
        req0_valid = 1'b0;
        req0_cmd   = mk_cmd(1'b0, 32'hFFFF_0000, 8'd255, 3'd7, 2'd3);
        #1;
        check("w_issue_en", {write_en, read_en}, 2'b10);
        check("w_addr", ax_addr, 32'h100);
        check("w_len_size_burst", {ax_len, ax_size, ax_burst}, {8'd3, 3'd2, 2'd1});
        check("w_grant", grant_id, 1'b0);
        check("w_busy_issue", busy, 1'b1);
        tick();
        #1;
        check("w_busy_en", {write_en, read_en, busy}, 3'b001);
        check("w_addr_held", ax_addr, 32'h100);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        #1;
        check("w_idle_after_done", busy, 1'b0);
        check("w_hold_after_done", {grant_id, ax_addr}, {1'b0, 32'h100});

        // ---------- both requesting continuously: 0,1,0,1 ----------
        do_reset();
        req0_cmd   = mk_cmd(1'b1, 32'h1000, 8'd1, 3'd2, 2'd1);
        req1_cmd   = mk_cmd(1'b0, 32'h2000, 8'd2, 3'd2, 2'd1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            exp_id = k[0];
            #1;
            check($sformatf("rr%0d_ready", k), {req0_ready, req1_ready}, exp_id ? 2'b01 : 2'b10);
            tick();
            #1;
            check($sformatf("rr%0d_grant", k), grant_id, exp_id);
            check($sformatf("rr%0d_en", k), {write_en, read_en}, exp_id ? 2'b01 : 2'b10);
            check($sformatf("rr%0d_addr", k), ax_addr, exp_id ? 32'h2000 : 32'h1000);
            check($sformatf("rr%0d_noready_issue", k), {req0_ready, req1_ready}, 2'b00);
            tick();
            for (int b = 0; b < 5; b++) begin
                xfer_done = (b == 4);
                #1;
                check($sformatf("rr%0d_busy%0d", k, b), {busy, req0_ready, req1_ready}, 3'b100);
                tick();
            end
            xfer_done = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // ---------- req1 read, done during ISSUE ignored ----------
        do_reset();
        req1_cmd   = mk_cmd(1'b0, 32'hA0, 8'd7, 3'd3, 2'd2);
        req1_valid = 1'b1;
        #1;
        check("r_ready", {req0_ready, req1_ready}, 2'b01);
        tick();
        req1_valid = 1'b0;
        xfer_done  = 1'b1;
        #1;
        check("r_issue_en", {write_en, read_en}, 2'b01);
        check("r_grant", grant_id, 1'b1);
        check("r_fields", {ax_addr, ax_len, ax_size, ax_burst}, {32'hA0, 8'd7, 3'd3, 2'd2});
        tick();
        xfer_done = 1'b0;
        #1;
        check("r_done_in_issue_ignored", {busy, write_en, read_en}, 3'b100);
        tick();
        xfer_done = 1'b1;
        tick();
        #1;
        check("r_idle_after_done", busy, 1'b0);
        tick();
        #1;
        check("r_done_in_idle_ignored", {busy, write_en, read_en}, 3'b000);
        xfer_done = 1'b0;

        // ---------- reset during BUSY with grant 1 ----------
        do_reset();
        req0_cmd   = mk_cmd(1'b1, 32'h300, 8'd0, 3'd0, 2'd0);
        req1_cmd   = mk_cmd(1'b1, 32'h400, 8'd4, 3'd1, 2'd1);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        xfer_done = 1'b1;
        tick();
        xfer_done  = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("mr_req1_alone", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        #1;
        check("mr_busy_grant1", {busy, grant_id}, 2'b11);
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mr_after_reset_req0_wins", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("mr_grant0", grant_id, 1'b0);

        // ---------- watchdog ----------
        do_reset();
        req0_cmd   = mk_cmd(1'b1, 32'h500, 8'd1, 3'd2, 2'd1);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int b = 1; b <= 8; b++) begin
            #1;
            check($sformatf("to_busy%0d", b), {busy, timeout_err}, {1'b1, b == 8});
            tick();
        end
        #1;
        check("to_idle_after", {busy, timeout_err}, 2'b00);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("to_ptr_updated", {req0_ready, req1_ready}, 2'b01);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`else
        for (int b = 0; b < 100; b++) begin
            #1;
            check($sformatf("nto_busy%0d", b), {busy, timeout_err}, 2'b10);
            tick();
        end
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        #1;
        check("nto_idle_after_done", busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_cmd_arbiter.md
AXI_CMD_ARBITER -- requirements
Module: axi_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the BUSY-state watchdog limit in m_aclk cycles (range 2..65535).
REQ-002 m_aclk  in  1  sole clock; all logic rising-edge.
REQ-003 m_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  in  1  requester 0 has a command.
REQ-005 req0_ready  out  1  requester 0 command accepted this cycle.
REQ-006 req0_cmd  in  46  {rw[45] (1=write), addr[44:13], len[12:5], size[4:2], burst[1:0]}.
REQ-007 req1_valid  in  1  requester 1 has a command.
REQ-008 req1_ready  out  1  requester 1 command accepted this cycle.
REQ-009 req1_cmd  in  46  same packing as req0_cmd.
REQ-010 write_en  out  1  one-cycle write start pulse to the AXI master.
REQ-011 read_en  out  1  one-cycle read start pulse to the AXI master.
REQ-012 ax_addr  out  32  drives both awaddr_ctrl and araddr_ctrl.
REQ-013 ax_len  out  8  drives awlen_ctrl/arlen_ctrl.
REQ-014 ax_size  out  3  drives awsize_ctrl/arsize_ctrl.
REQ-015 ax_burst  out  2  drives awburst_ctrl/arburst_ctrl.
REQ-016 xfer_done  in  1  one-cycle pulse from the master when the issued transfer completes.
REQ-017 grant_id  out  1  index of the requester owning the current transfer.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 timeout_err  out  1  one-cycle watchdog-expiry pulse.

Function
REQ-020 SHALL implement states IDLE, ISSUE, BUSY.
REQ-021 IDLE: if any reqN_valid, the winner's reqN_ready SHALL be asserted combinationally that cycle; the command and grant_id SHALL be registered; next state ISSUE.
REQ-022 Arbitration SHALL be round-robin: with both valid, the requester not granted most recently wins; after reset requester 0 has priority.
REQ-023 With a single requester valid, that requester SHALL win regardless of the pointer.
REQ-024 reqN_ready SHALL be 0 outside IDLE, and at most one reqN_ready SHALL be high in any cycle.
REQ-025 ISSUE SHALL last exactly one cycle, asserting write_en if rw=1, else read_en, never both; next state BUSY.
REQ-026 ax_* and grant_id SHALL be held stable from ISSUE until the next acceptance.
REQ-027 Latency: accept at cycle N gives the en pulse at N+1 and BUSY from N+2.
REQ-028 BUSY: xfer_done=1 SHALL return the block to IDLE next cycle and set the RR pointer to grant_id.
REQ-029 xfer_done SHALL be ignored in IDLE and ISSUE.
REQ-030 Back-to-back: done at cycle M allows acceptance at M+1 and the en pulse at M+2.
REQ-031 reqN_cmd SHALL NOT be sampled except in the acceptance cycle.

Reset
REQ-032 While m_aresetn=0: state IDLE, RR pointer to requester 0, all outputs 0 (ax_* = 0, grant_id = 0, busy = 0, en pulses = 0, timeout_err = 0).
REQ-033 Reset asserted mid-transfer SHALL abort immediately with no en pulse; operation resumes in IDLE on the first edge after deassertion.

Configuration
REQ-034 Macro ARB_TIMEOUT_EN SHALL compile in a 16-bit BUSY-cycle watchdog counter, cleared on entry to BUSY.
REQ-035 With ARB_TIMEOUT_EN defined: if the counter reaches TIMEOUT_CYCLES-1 without xfer_done, timeout_err SHALL pulse for one cycle, state SHALL go to IDLE, and the pointer SHALL update as if done.
REQ-036 Without ARB_TIMEOUT_EN: timeout_err SHALL be tied 0, BUSY SHALL wait indefinitely, and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-037 req0 write cmd (addr 0x100, len 3, size 2, burst 1), req1 idle -> req0_ready at N, write_en at N+1, ax_addr=0x100, ax_len=3, grant_id=0.
REQ-038 Both valid continuously after reset, done after 5 BUSY cycles each -> grants alternate 0,1,0,1; never two ready at once.
REQ-039 req1 read cmd -> read_en pulse only, write_en stays 0; xfer_done in the ISSUE cycle is ignored, and done in BUSY returns to IDLE.
REQ-040 m_aresetn pulsed low in BUSY with grant_id=1 -> all outputs 0 at once; the next simultaneous request is granted to req0.
REQ-041 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no xfer_done -> timeout_err pulse on the 8th BUSY cycle, busy=0 next cycle; without the macro, busy stays 1 for 100 cycles.
